// File: rtl/alu_stage_pkg.sv
// alu_stage_pkg
//   Shared types for the ALU stage that sits downstream of the 16-bit shifter.
//   aluop_t  : operation select carried on the 2-bit aluop bus
//   status_t : status flags, packed so that {n,v,z} maps to status_out[2:0]
//   state_t  : occupancy state of the single-entry output register
package alu_stage_pkg;

    typedef enum logic [1:0] {
        ALU_ADD = 2'b00,
        ALU_SUB = 2'b01,
        ALU_AND = 2'b10,
        ALU_NOT = 2'b11
    } aluop_t;

    typedef struct packed {
        logic n;
        logic v;
        logic z;
    } status_t;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

endpackage : alu_stage_pkg

// File: rtl/alu_stage_if.sv
// alu_stage_if
//   Bundles the operand-side and result-side handshakes of the ALU stage.
//   Operand side : in_valid, in_ready, ain, bin, asel, aluop, loads
//   Result side  : out_valid, out_ready, c_out, status_out ({N,V,Z})
//   modport slave  : the ALU stage itself
//   modport master : the environment (register file / shifter and writeback mux)
interface alu_stage_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] ain;
    logic [WIDTH-1:0] bin;
    logic             asel;
    logic [1:0]       aluop;
    logic             loads;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] c_out;
    logic [2:0]       status_out;

    modport slave (
        input  in_valid, ain, bin, asel, aluop, loads, out_ready,
        output in_ready, out_valid, c_out, status_out
    );

    modport master (
        output in_valid, ain, bin, asel, aluop, loads, out_ready,
        input  in_ready, out_valid, c_out, status_out
    );
endinterface : alu_stage_if

// File: rtl/alu_core.sv
// alu_core
//   Purely combinational ALU: ADD, SUB (A-B), AND, NOT B, plus {N,V,Z} flags
//   computed on the value that will be written to C.
//   Build option: define ALU_STAGE_SAT_EN to clamp ADD/SUB signed overflow to
//   the signed max/min; V still reports the overflow.
//   Ports:
//     a      in  WIDTH  A operand, already zeroed when asel=1
//     b      in  WIDTH  B operand (shifter output)
//     op     in  2      operation select (aluop_t)
//     result out WIDTH  result C
//     flags  out 3      {n,v,z} for result
module alu_core
    import alu_stage_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  aluop_t           op,
    output logic [WIDTH-1:0] result,
    output status_t          flags
);

    localparam int               MSB = WIDTH - 1;
    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] diff;
    logic             ovf;

    assign sum  = a + b;
    assign diff = a + ~b + ONE;

`ifdef ALU_STAGE_SAT_EN
    localparam logic [WIDTH-1:0] SMAX = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] SMIN = {1'b1, {(WIDTH-1){1'b0}}};
`endif

    // NOTE: every signal written in this block gets a default first, so no
    // path through the case can leave it unassigned and infer a latch.
    always_comb begin
        result = '0;
        ovf    = 1'b0;
        case (op)
            ALU_ADD: begin
                result = sum;
                ovf    = (a[MSB] == b[MSB]) && (sum[MSB] != a[MSB]);
            end
            ALU_SUB: begin
                result = diff;
                ovf    = (a[MSB] != b[MSB]) && (diff[MSB] != a[MSB]);
            end
            ALU_AND: result = a & b;
            ALU_NOT: result = ~b;
            default: result = '0;
        endcase
`ifdef ALU_STAGE_SAT_EN
        // For both ADD and SUB the overflow direction follows A's sign:
        // a non-negative A can only overflow upward, a negative A downward.
        if (ovf) begin
            result = a[MSB] ? SMIN : SMAX;
        end
`endif
    end

    assign flags = '{n: result[MSB], v: ovf, z: (result == '0)};

endmodule : alu_core

// File: rtl/alu_stage.sv
// alu_stage
//   ALU datapath stage downstream of the shifter. Computes C from A' and the
//   shifted B, registers C and the status flags, and presents the result on a
//   single-entry valid/ready output register. Upstream is stalled while an
//   unconsumed result is held and the consumer is not ready.
//   Build option: ALU_STAGE_SAT_EN (saturating ADD/SUB, see alu_core).
//   Ports:
//     clk      in   rising-edge clock
//     reset_n  in   synchronous active-low reset
//     bus      slave modport of alu_stage_if (operand and result handshakes)
module alu_stage
    import alu_stage_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic        clk,
    input  logic        reset_n,
    alu_stage_if.slave  bus
);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] c_q;
    status_t          status_q;

    logic             accept;
    logic             release_c;
    logic             load_c;
    logic             out_valid;
    logic             in_ready;

    logic [WIDTH-1:0] a_eff;
    logic [WIDTH-1:0] alu_result;
    status_t          alu_flags;

    assign a_eff = bus.asel ? '0 : bus.ain;

    alu_core #(.WIDTH(WIDTH)) u_core (
        .a      (a_eff),
        .b      (bus.bin),
        .op     (aluop_t'(bus.aluop)),
        .result (alu_result),
        .flags  (alu_flags)
    );

    // A full stage may accept in the same cycle its result is drained.
    assign out_valid = (state_q == FULL);
    assign in_ready  = !out_valid || bus.out_ready;
    assign accept    = bus.in_valid && in_ready;
    assign release_c = out_valid && bus.out_ready;

    always_comb begin
        state_d = state_q;
        load_c  = 1'b0;
        case (state_q)
            EMPTY: begin
                if (accept) begin
                    state_d = FULL;
                    load_c  = 1'b1;
                end
            end
            FULL: begin
                // In FULL, accept implies out_ready and hence release.
                if (accept) begin
                    load_c = 1'b1;
                end else if (release_c) begin
                    state_d = EMPTY;
                end
            end
            default: state_d = EMPTY;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order; reset is
    // synchronous and takes priority over any transfer in the same cycle.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q  <= EMPTY;
            c_q      <= '0;
            status_q <= '0;
        end else begin
            state_q <= state_d;
            if (load_c) begin
                c_q <= alu_result;
            end
            if (accept && bus.loads) begin
                status_q <= alu_flags;
            end
        end
    end

    assign bus.out_valid  = out_valid;
    assign bus.in_ready   = in_ready;
    assign bus.c_out      = c_q;
    assign bus.status_out = status_q;

endmodule : alu_stage

// File: tb/tb_alu_stage.sv
// tb_alu_stage
//   Directed bench for alu_stage: a table of single-op vectors with
//   hand-computed results, plus sequences for backpressure, back-to-back
//   throughput and reset during a held result.
module tb_alu_stage;

    localparam int WIDTH = 16;

    logic clk;
    logic reset_n;
    int   n_cmp;
    int   n_bad;

    alu_stage_if #(.WIDTH(WIDTH)) bus ();

    alu_stage #(.WIDTH(WIDTH)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] ain;
        logic [15:0] bin;
        logic        asel;
        logic [1:0]  aluop;
        logic        loads;
        logic [15:0] exp_c;
        logic [2:0]  exp_st;
    } vec_t;

    vec_t vecs [10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic after_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [15:0] a, input logic [15:0] b, input logic s,
                         input logic [1:0] op, input logic ld);
        bus.ain   = a;
        bus.bin   = b;
        bus.asel  = s;
        bus.aluop = op;
        bus.loads = ld;
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;

        // {ain, bin, asel, aluop, loads, expected c, expected {N,V,Z}}
`ifdef ALU_STAGE_SAT_EN
        vecs[0] = '{16'h7FFF, 16'h0001, 1'b0, 2'b00, 1'b1, 16'h7FFF, 3'b010};
`else
        vecs[0] = '{16'h7FFF, 16'h0001, 1'b0, 2'b00, 1'b1, 16'h8000, 3'b110};
`endif
        vecs[1] = '{16'h1234, 16'h1234, 1'b0, 2'b01, 1'b1, 16'h0000, 3'b001};
        vecs[2] = '{16'h5555, 16'h00FF, 1'b1, 2'b11, 1'b0, 16'hFF00, 3'b001};
        vecs[3] = '{16'hF0F0, 16'h3C3C, 1'b0, 2'b10, 1'b1, 16'h3030, 3'b000};
`ifdef ALU_STAGE_SAT_EN
        vecs[4] = '{16'h8000, 16'h0001, 1'b0, 2'b01, 1'b1, 16'h8000, 3'b110};
`else
        vecs[4] = '{16'h8000, 16'h0001, 1'b0, 2'b01, 1'b1, 16'h7FFF, 3'b010};
`endif
        vecs[5] = '{16'h0003, 16'h0005, 1'b0, 2'b01, 1'b1, 16'hFFFE, 3'b100};
        vecs[6] = '{16'h1111, 16'h0022, 1'b1, 2'b00, 1'b1, 16'h0022, 3'b000};
`ifdef ALU_STAGE_SAT_EN
        vecs[7] = '{16'h8000, 16'h8000, 1'b0, 2'b00, 1'b1, 16'h8000, 3'b110};
`else
        vecs[7] = '{16'h8000, 16'h8000, 1'b0, 2'b00, 1'b1, 16'h0000, 3'b011};
`endif
        vecs[8] = '{16'h0000, 16'hFFFF, 1'b0, 2'b11, 1'b1, 16'h0000, 3'b001};
        vecs[9] = '{16'hFFFF, 16'h00A5, 1'b0, 2'b10, 1'b0, 16'h00A5, 3'b001};

        // Reset and idle
        reset_n       = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        drive(16'h0, 16'h0, 1'b0, 2'b00, 1'b0);
        after_edge();
        after_edge();
        reset_n = 1'b1;
        after_edge();
        check("reset out_valid", 32'(bus.out_valid), 32'd0);
        check("reset c_out", 32'(bus.c_out), 32'h0);
        check("reset status", 32'(bus.status_out), 32'h0);
        check("reset in_ready", 32'(bus.in_ready), 32'd1);

        // Table-driven single ops; each result drains as the next op enters
        for (int i = 0; i < 10; i++) begin
            drive(vecs[i].ain, vecs[i].bin, vecs[i].asel, vecs[i].aluop, vecs[i].loads);
            bus.in_valid = 1'b1;
            @(negedge clk);
            check($sformatf("vec%0d in_ready", i), 32'(bus.in_ready), 32'd1);
            after_edge();
            check($sformatf("vec%0d out_valid", i), 32'(bus.out_valid), 32'd1);
            check($sformatf("vec%0d c_out", i), 32'(bus.c_out), 32'(vecs[i].exp_c));
            check($sformatf("vec%0d status", i), 32'(bus.status_out), 32'(vecs[i].exp_st));
        end
        bus.in_valid = 1'b0;
        after_edge();
        check("drain out_valid", 32'(bus.out_valid), 32'd0);
        check("drain c_out retained", 32'(bus.c_out), 32'h00A5);

        // Backpressure: result 5 held while consumer stalls
        bus.out_ready = 1'b0;
        drive(16'h0002, 16'h0003, 1'b0, 2'b00, 1'b1);
        bus.in_valid = 1'b1;
        after_edge();
        check("bp first c_out", 32'(bus.c_out), 32'h0005);
        drive(16'h0010, 16'h0010, 1'b0, 2'b00, 1'b1);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check($sformatf("bp%0d in_ready", k), 32'(bus.in_ready), 32'd0);
            check($sformatf("bp%0d out_valid", k), 32'(bus.out_valid), 32'd1);
            check($sformatf("bp%0d c_out", k), 32'(bus.c_out), 32'h0005);
            after_edge();
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
        check("bp release in_ready", 32'(bus.in_ready), 32'd1);
        after_edge();
        check("bp pending c_out", 32'(bus.c_out), 32'h0020);
        check("bp pending out_valid", 32'(bus.out_valid), 32'd1);
        bus.in_valid = 1'b0;
        after_edge();
        check("bp empty out_valid", 32'(bus.out_valid), 32'd0);
        check("bp c_out retained", 32'(bus.c_out), 32'h0020);
        check("bp status", 32'(bus.status_out), 32'h0);

        // Back-to-back throughput
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            drive(16'(i), 16'(i), 1'b0, 2'b00, 1'b1);
            after_edge();
            check($sformatf("b2b%0d out_valid", i), 32'(bus.out_valid), 32'd1);
            check($sformatf("b2b%0d c_out", i), 32'(bus.c_out), 32'(2 * i));
        end
        bus.in_valid = 1'b0;
        after_edge();
        check("b2b drained", 32'(bus.out_valid), 32'd0);

        // Reset while FULL and stalled, with a new op presented
        bus.out_ready = 1'b0;
        drive(16'h0003, 16'h0005, 1'b0, 2'b01, 1'b1);
        bus.in_valid = 1'b1;
        after_edge();
        check("rst-mid pre c_out", 32'(bus.c_out), 32'hFFFE);
        check("rst-mid pre status", 32'(bus.status_out), 32'h4);
        bus.out_ready = 1'b1;
        drive(16'h0007, 16'h0001, 1'b0, 2'b00, 1'b1);
        reset_n = 1'b0;
        after_edge();
        check("rst-mid out_valid", 32'(bus.out_valid), 32'd0);
        check("rst-mid c_out", 32'(bus.c_out), 32'h0);
        check("rst-mid status", 32'(bus.status_out), 32'h0);
        reset_n      = 1'b1;
        bus.in_valid = 1'b0;
        after_edge();
        check("rst-mid not captured", 32'(bus.out_valid), 32'd0);
        check("rst-mid c_out after", 32'(bus.c_out), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_alu_stage

// File: doc/alu_stage.md
Name: alu_stage

Overview:
- Datapath stage directly downstream of the 16-bit shifter. Consumes the shifted B operand (shifter output) plus the A operand.
- Computes ADD/SUB/AND/NOT and registers result C and status flags {N,V,Z}.
- Single-entry output register with valid/ready handshake. Stalls the register-file/shifter side when the consumer (writeback mux) is not ready.

Parameters:
- WIDTH, 16, datapath width in bits for ain, bin and c_out.

Ports:
- clk  in  1  rising-edge clock
- reset_n  in  1  synchronous active-low reset
- in_valid  in  1  operands and op valid this cycle
- in_ready  out  1  stage can accept operands this cycle
- ain  in  WIDTH  A operand from load register A
- bin  in  WIDTH  B operand from shifter output
- asel  in  1  1: A operand forced to 0; 0: ain
- aluop  in  2  00 ADD, 01 SUB (A-B), 10 AND, 11 NOT B
- loads  in  1  update status register on accept
- out_valid  out  1  c_out holds an unconsumed result
- out_ready  in  1  consumer takes c_out this cycle
- c_out  out  WIDTH  registered result C
- status_out  out  3  registered status {N,V,Z}, bit2=N, bit1=V, bit0=Z

Behaviour:
- Reset (reset_n=0 at posedge):
  - c_out=0, out_valid=0, status_out=3'b000, FSM=EMPTY.
  - Reset overrides any simultaneous transfer. A result mid-handshake is discarded.
- Transfers:
  - Accept = in_valid && in_ready.
  - Release = out_valid && out_ready.
- in_ready = !out_valid || out_ready. This is combinational, so a full stage accepts in the same cycle the consumer drains.
- FSM:
  - EMPTY: accept -> FULL (c_out loaded). No accept -> stay EMPTY.
  - FULL, release && accept: stay FULL, c_out <= new result.
  - FULL, release && !accept: -> EMPTY, c_out retains its last value.
  - FULL, !release: hold. c_out and out_valid stable. in_ready=0.
  - out_valid=1 iff FSM=FULL.
- Latency: 1 cycle, accept at edge k -> out_valid high after edge k.
- Arithmetic (A' = asel ? 0 : ain):
  - ADD: A'+bin mod 2^WIDTH.
  - SUB: A'+~bin+1 mod 2^WIDTH.
  - AND: A'&bin.
  - NOT: ~bin, A' ignored.
- Flags, computed on the result written to c_out:
  - Z = (result==0).
  - N = result[WIDTH-1].
  - V:
    - ADD: signs of A' and bin equal and result sign differs.
    - SUB: signs of A' and bin differ and result sign differs from A'.
    - AND/NOT: V=0.
- Status register:
  - Updates only on an accepted op with loads=1.
  - Persists across releases and idle cycles.
  - Accept with loads=0 leaves status unchanged.
- Inputs are ignored when in_ready=0. Upstream must hold operands stable until accepted.
- aluop is fully decoded; there is no X result for any input combination.

Optional Feature:
- Macro: ALU_STAGE_SAT_EN.
- Defined:
  - ADD/SUB saturate on signed overflow: positive overflow -> 0x7FFF, negative overflow -> 0x8000 (for WIDTH=16, generally the signed max/min).
  - V still reports 1. N and Z are computed on the saturated value.
- Undefined: wrap-around as above. No saturation logic is synthesized.

Decomposition:
- alu_stage_pkg holds:
  - aluop_t enum {ALU_ADD, ALU_SUB, ALU_AND, ALU_NOT}
  - status_t packed struct {n,v,z}
  - state_t enum {EMPTY, FULL}
- Sub-module alu_core: purely combinational. Takes A', bin and aluop; returns result and flags, including the saturation path under the macro.
- alu_stage holds the FSM, C register, status register and handshake.

Test Plan:
- Reset and idle: hold reset_n=0 for 2 cycles, then release -> out_valid=0, c_out=0, status=000, in_ready=1.
- ADD overflow: ain=0x7FFF, bin=0x0001, ADD, loads=1 -> next cycle c_out=0x8000, status N=1,V=1,Z=0. With ALU_STAGE_SAT_EN: c_out=0x7FFF, N=0,V=1,Z=0.
- SUB to zero plus asel/NOT:
  - ain=0x1234, bin=0x1234, SUB -> c_out=0, Z=1.
  - Then asel=1, bin=0x00FF, NOT, loads=0 -> c_out=0xFF00, status still Z=1.
- Backpressure: out_ready=0 after a result 0x0005 -> in_ready=0 and c_out stable 0x0005 for 3 cycles despite new in_valid. Raising out_ready accepts the pending op in that same cycle.
- Back-to-back throughput: out_ready=1, in_valid=1 for 4 ops (ADD 1+1, 2+2, 3+3, 4+4) -> c_out 2,4,6,8 on 4 consecutive cycles, out_valid continuously 1.
- Reset mid-operation: FULL with out_ready=0, assert reset_n=0 for one edge alongside in_valid=1 -> out_valid=0, c_out=0, status=000, the new op is not captured.
